// File: rtl/regfile_port_ctrl.sv
// Regfile port controller: sweeps registers 1..NUM_REGS-1 to INIT_VALUE after reset,
// then arbitrates the write port and read port 1 between the pipeline and a host agent.
module regfile_port_ctrl #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 5,
  parameter int unsigned       NUM_REGS     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
  parameter int unsigned       STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              stall_req,
  output logic              init_done,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              id_re1,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              host_rd_valid,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_ready,
  output logic              host_rd_rvalid,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_re1,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1
);

  localparam int unsigned       WAIT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wr_wait_q, wr_wait_d;
  logic [WAIT_W-1:0]   rd_wait_q, rd_wait_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_hs;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_wait_d     = '0;
    rd_wait_d     = '0;
    stall_req     = 1'b1;
    init_done     = 1'b0;
    host_wr_ready = 1'b0;
    host_rd_ready = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    rf_re1        = 1'b0;
    rf_raddr1     = '0;

    case (state_q)
      ST_INIT: begin
        rf_we    = 1'b1;
        rf_waddr = cnt_q;
        rf_wdata = INIT_VALUE;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        stall_req = (wr_wait_q == WAIT_MAX) || (rd_wait_q == WAIT_MAX);

        if (wb_we) begin
          rf_we    = 1'b1;
          rf_waddr = wb_waddr;
          rf_wdata = wb_wdata;
        end else begin
          host_wr_ready = 1'b1;
          if (host_wr_valid) begin
            rf_we    = 1'b1;
            rf_waddr = host_wr_addr;
            rf_wdata = host_wr_data;
          end
        end

        if (id_re1) begin
          rf_re1    = 1'b1;
          rf_raddr1 = id_raddr1;
        end else begin
          host_rd_ready = 1'b1;
          if (host_rd_valid) begin
            rf_re1    = 1'b1;
            rf_raddr1 = host_rd_addr;
          end
        end

        // Wait counters clear whenever the host is not blocked (handshake or valid low).
        if (host_wr_valid && !host_wr_ready) begin
          wr_wait_d = (wr_wait_q == WAIT_MAX) ? wr_wait_q : wr_wait_q + 1'b1;
        end
        if (host_rd_valid && !host_rd_ready) begin
          rd_wait_d = (rd_wait_q == WAIT_MAX) ? rd_wait_q : rd_wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Reset gates the ports directly since state may still read RUN during the rst cycle.
    if (rst) begin
      stall_req     = 1'b1;
      init_done     = 1'b0;
      host_wr_ready = 1'b0;
      host_rd_ready = 1'b0;
      rf_we         = 1'b0;
      rf_waddr      = '0;
      rf_wdata      = '0;
      rf_re1        = 1'b0;
      rf_raddr1     = '0;
    end
  end

  assign rd_hs = host_rd_valid && host_rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= ADDR_W'(1);
      wr_wait_q <= '0;
      rd_wait_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_wait_q <= wr_wait_d;
      rd_wait_q <= rd_wait_d;
      rvalid_q  <= rd_hs;
      if (rd_hs) begin
        rdata_q <= rf_rdata1;
      end
    end
  end

  assign host_rd_rvalid = rvalid_q;
  assign host_rd_data   = rdata_q;

endmodule
